// File: rtl/mem_access_unit.sv
// mem_access_unit: word-wide memory access sequencer between the multicycle
// core and a single-ported valid/ready memory bus. Fetches into the
// instruction register, loads into the data register, performs stores, and
// holds the control FSM (busy) until each access finishes (done pulse).
module mem_access_unit #(
   parameter int          TIMEOUT     = 16,
   parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        access_req,
   input  logic        mem_addr_src,
   input  logic        mem_we,
   input  logic        instr_we,
   input  logic [31:0] pc,
   input  logic [31:0] data_addr,
   input  logic [31:0] wdata,
   output logic        bus_valid,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata,
   output logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [31:0] old_pc,
   output logic [31:0] data_q,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   // Last wait-counter value before the access is abandoned; with the counter
   // starting at 0 on entry this keeps bus_valid up for exactly TIMEOUT cycles.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic        req_iwe;
   logic [31:0] sel_addr;
   logic        accept;
   logic        misaligned;
   logic        handshake;
   logic        expired;

   assign sel_addr   = mem_addr_src ? data_addr : pc;
   assign accept     = (state == IDLE) && access_req;
   assign misaligned = (sel_addr[1:0] != 2'b00);
   // bus_valid is only high in ACCESS, so ready outside a request is ignored.
   assign handshake  = (state == ACCESS) && bus_valid && bus_ready;
   assign expired    = (state == ACCESS) && !bus_ready && (wait_cnt == WAIT_LAST);

   assign busy   = (state != IDLE);
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Sequencer FSM: accept, wait for handshake or timeout, pulse done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         bus_valid <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
         wait_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (access_req) begin
                  if (misaligned) begin
                     // Never reaches the bus; report completion with fault.
                     fault <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     wait_cnt  <= '0;
                     bus_valid <= 1'b1;
                     state     <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (handshake) begin
                  bus_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end else if (expired) begin
                  bus_valid <= 1'b0;
                  fault     <= 1'b1;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Request registers: frozen from acceptance until the next accepted access,
   // so address/data/we are stable across the whole handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_we    <= 1'b0;
         req_iwe   <= 1'b0;
      end else if (accept) begin
         bus_addr  <= sel_addr;
         bus_wdata <= wdata;
         bus_we    <= mem_we;
         // A write wins over an instruction-register update.
         req_iwe   <= instr_we && !mem_we;
      end
   end

   // Result registers: capture read data on the handshake edge only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr  <= RESET_INSTR;
         old_pc <= '0;
         data_q <= '0;
      end else if (handshake && !bus_we) begin
         if (req_iwe) begin
            instr  <= bus_rdata;
            old_pc <= bus_addr;
         end else begin
            data_q <= bus_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4). Bus-side memory behaviour
// is driven by the bench; expected values are hand-computed constants.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        access_req;
   logic        mem_addr_src;
   logic        mem_we;
   logic        instr_we;
   logic [31:0] pc;
   logic [31:0] data_addr;
   logic [31:0] wdata;
   logic        bus_valid;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] old_pc;
   logic [31:0] data_q;
   logic        busy;
   logic        done;
   logic        fault;

   int n_vec = 0;
   int n_err = 0;

   // Per-cycle activity counters, sampled mid-cycle.
   int vcyc = 0;
   int dcnt = 0;
   int hs   = 0;

   mem_access_unit #(.TIMEOUT(4), .RESET_INSTR(32'h0000_0013)) dut (
      .clk(clk), .rst(rst), .access_req(access_req), .mem_addr_src(mem_addr_src),
      .mem_we(mem_we), .instr_we(instr_we), .pc(pc), .data_addr(data_addr),
      .wdata(wdata), .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
      .instr(instr), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .old_pc(old_pc), .data_q(data_q), .busy(busy), .done(done), .fault(fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      vcyc += int'(bus_valid);
      dcnt += int'(done);
      hs   += int'(bus_valid & bus_ready);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access: request, 'waits' cycles with ready low, then ready with rd.
   // Returns in the cycle after the handshake edge (done expected high).
   task automatic do_access(input logic src, input logic we, input logic iwe,
                            input logic [31:0] p, input logic [31:0] da,
                            input logic [31:0] wd, input int waits,
                            input logic [31:0] rd);
      mem_addr_src = src; mem_we = we; instr_we = iwe;
      pc = p; data_addr = da; wdata = wd; bus_ready = 1'b0;
      access_req = 1'b1;
      tick();
      access_req = 1'b0;
      chk("acc_valid", 32'(bus_valid), 32'd1);
      chk("acc_addr", bus_addr, src ? da : p);
      chk("acc_we", 32'(bus_we), 32'(we));
      for (int w = 0; w < waits; w++) tick();
      bus_ready = 1'b1; bus_rdata = rd;
      tick();
      bus_ready = 1'b0;
      chk("acc_done", 32'(done), 32'd1);
   endtask

   initial begin
      int v0, d0, h0;
      rst = 1'b1; access_req = 1'b0; mem_addr_src = 1'b0; mem_we = 1'b0;
      instr_we = 1'b0; pc = '0; data_addr = '0; wdata = '0;
      bus_ready = 1'b0; bus_rdata = '0;
      #3 rst = 1'b0;
      #1;
      // Reset state
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_opcode", 32'(opcode), 32'h13);
      chk("rst_oldpc", old_pc, 32'h0);
      chk("rst_dataq", data_q, 32'h0);
      chk("rst_ctl", {27'd0, bus_valid, bus_we, busy, done, fault}, 32'h0);
      tick(); tick();
      rst = 1'b1;
      tick();

      // Fetch with 2 wait cycles
      v0 = vcyc; d0 = dcnt;
      do_access(1'b0, 1'b0, 1'b1, 32'h100, 32'h0, 32'h0, 2, 32'h0050_0093);
      chk("fetch_busy_done", 32'(busy), 32'd1);
      tick();
      chk("fetch_idle", {30'd0, busy, done}, 32'h0);
      chk("fetch_vcyc", 32'(vcyc - v0), 32'd3);
      chk("fetch_dcnt", 32'(dcnt - d0), 32'd1);
      chk("fetch_instr", instr, 32'h0050_0093);
      chk("fetch_opcode", 32'(opcode), 32'h13);
      chk("fetch_oldpc", old_pc, 32'h100);
      chk("fetch_dataq", data_q, 32'h0);

      // Load
      do_access(1'b1, 1'b0, 1'b0, 32'h104, 32'h200, 32'h0, 0, 32'hDEAD_BEEF);
      tick();
      chk("load_dataq", data_q, 32'hDEAD_BEEF);
      chk("load_instr", instr, 32'h0050_0093);

      // Store (instr_we also set, must be ignored)
      mem_addr_src = 1'b1; mem_we = 1'b1; instr_we = 1'b1;
      data_addr = 32'h204; wdata = 32'h1234_5678; access_req = 1'b1;
      tick();
      access_req = 1'b0;
      chk("st_valid", 32'(bus_valid), 32'd1);
      chk("st_we", 32'(bus_we), 32'd1);
      chk("st_addr", bus_addr, 32'h204);
      chk("st_wdata", bus_wdata, 32'h1234_5678);
      bus_ready = 1'b1; bus_rdata = 32'hAAAA_AAAA;
      tick();
      bus_ready = 1'b0;
      chk("st_done", 32'(done), 32'd1);
      tick();
      chk("st_instr", instr, 32'h0050_0093);
      chk("st_oldpc", old_pc, 32'h100);
      chk("st_dataq", data_q, 32'hDEAD_BEEF);
      mem_we = 1'b0;

      // Timeout: ready held low
      v0 = vcyc;
      mem_addr_src = 1'b1; instr_we = 1'b0; data_addr = 32'h208; access_req = 1'b1;
      tick();
      access_req = 1'b0;
      chk("to_fault_before", 32'(fault), 32'd0);
      begin
         int n;
         n = 0;
         while (!done && n < 20) begin tick(); n++; end
         chk("to_done_seen", 32'(done), 32'd1);
         chk("to_cycles", 32'(n), 32'd4);
      end
      chk("to_fault", 32'(fault), 32'd1);
      chk("to_valid_low", 32'(bus_valid), 32'd0);
      tick();
      chk("to_vcyc", 32'(vcyc - v0), 32'd4);
      chk("to_instr", instr, 32'h0050_0093);
      chk("to_dataq", data_q, 32'hDEAD_BEEF);

      // Reset mid-ACCESS
      d0 = dcnt;
      mem_addr_src = 1'b0; instr_we = 1'b1; pc = 32'h180; access_req = 1'b1;
      tick();
      access_req = 1'b0;
      tick();
      chk("mid_valid", 32'(bus_valid), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus_valid), 32'd0);
      chk("mid_rst_instr", instr, 32'h0000_0013);
      chk("mid_rst_ctl", {29'd0, busy, done, fault}, 32'h0);
      chk("mid_rst_dataq", data_q, 32'h0);
      tick();
      rst = 1'b1;
      tick(); tick();
      chk("mid_no_done", 32'(dcnt - d0), 32'd0);

      // Fetch after reset
      do_access(1'b0, 1'b0, 1'b1, 32'h300, 32'h0, 32'h0, 1, 32'h00A0_0113);
      tick();
      chk("post_instr", instr, 32'h00A0_0113);
      chk("post_oldpc", old_pc, 32'h300);
      chk("post_fault", 32'(fault), 32'd0);

      // Misaligned
      v0 = vcyc;
      mem_addr_src = 1'b1; instr_we = 1'b0; data_addr = 32'h202; access_req = 1'b1;
      tick();
      access_req = 1'b0;
      chk("mis_done", 32'(done), 32'd1);
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_valid", 32'(bus_valid), 32'd0);
      tick();
      chk("mis_busy", 32'(busy), 32'd0);
      chk("mis_vcyc", 32'(vcyc - v0), 32'd0);

      // Good load afterwards: fault sticky
      do_access(1'b1, 1'b0, 1'b0, 32'h0, 32'h400, 32'h0, 0, 32'h0000_0055);
      tick();
      chk("sticky_dataq", data_q, 32'h0000_0055);
      chk("sticky_fault", 32'(fault), 32'd1);

      // access_req pulses while busy are ignored
      h0 = hs; d0 = dcnt;
      mem_addr_src = 1'b0; instr_we = 1'b1; pc = 32'h600; access_req = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         pc = 32'h700 + 32'(i * 4);
         access_req = 1'(i % 2);
         tick();
         chk("busy_addr", bus_addr, 32'h600);
      end
      access_req = 1'b0; bus_ready = 1'b1; bus_rdata = 32'h0000_0073;
      tick();
      bus_ready = 1'b0;
      tick(); tick();
      chk("busy_hs", 32'(hs - h0), 32'd1);
      chk("busy_dcnt", 32'(dcnt - d0), 32'd1);
      chk("busy_oldpc", old_pc, 32'h600);

      // Back-to-back with ready held: one access per 3 cycles
      h0 = hs; d0 = dcnt;
      mem_addr_src = 1'b0; instr_we = 1'b1; pc = 32'h500;
      bus_rdata = 32'h0000_0033; bus_ready = 1'b1; access_req = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      access_req = 1'b0; bus_ready = 1'b0;
      chk("b2b_hs", 32'(hs - h0), 32'd3);
      chk("b2b_dcnt", 32'(dcnt - d0), 32'd3);
      chk("b2b_instr", instr, 32'h0000_0033);
      chk("b2b_oldpc", old_pc, 32'h500);
      chk("b2b_funct", {22'd0, funct7, funct3}, 32'h0);
      tick(); tick();
      chk("b2b_idle", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
